// File: rtl/sfr_ext_if.sv
// MemSplit32: split request/response 32-bit register bus (request accepted via ack, read data via resp). Rev 1.0
`default_nettype none

interface MemSplit32;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic        resp;
  logic [31:0] rdata;

  modport Slave  (input req, we, addr, wdata, output ack, resp, rdata);
  modport Master (output req, we, addr, wdata, input ack, resp, rdata);
endinterface

`default_nettype wire

// File: rtl/sfr_ext.sv
// sfr_ext: CPU control, SGI FIFO and optional timer (macro SFR_EXT_TIMER_EN) behind a MemSplit32 slave. Rev 1.0
`default_nettype none

module sfr_ext #(
  parameter int CORENUM           = 0,
  parameter int CPU_RESET_DEFAULT = 0,
  parameter int IRQ_NUM_POW       = 4,
  parameter int SGI_FIFO_POW      = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  MemSplit32.Slave               host,
  output logic                   cpu_reset_o,
  output logic                   sgi_req_o,
  output logic [IRQ_NUM_POW-1:0] sgi_code_bo,
  input  logic                   sgi_ack_i,
  output logic                   timer_irq_o
);

  localparam int DEPTH = 1 << SGI_FIFO_POW;
  localparam int CW    = SGI_FIFO_POW + 1;

  localparam logic [7:0] A_IDCODE     = 8'h00;
  localparam logic [7:0] A_CTRL       = 8'h04;
  localparam logic [7:0] A_CORENUM    = 8'h08;
  localparam logic [7:0] A_MSI        = 8'h0C;
  localparam logic [7:0] A_SGI_STATUS = 8'h10;
  localparam logic [7:0] A_TIMER_CNT  = 8'h14;
  localparam logic [7:0] A_TIMER_CMP  = 8'h18;
  localparam logic [7:0] A_TIMER_CTRL = 8'h1C;

  logic [7:0] reg_addr;
  logic       wr_en;
  logic       rd_en;

  assign reg_addr  = host.addr[7:0];
  assign wr_en     = host.req & host.we;
  assign rd_en     = host.req & ~host.we;
  assign host.ack  = host.req;

  logic unused_bits;
  assign unused_bits = &{1'b0, host.addr[31:8], host.wdata};

  // ---------------- SGI FIFO ----------------
  logic [IRQ_NUM_POW-1:0]  fifo_mem [DEPTH];
  logic [SGI_FIFO_POW-1:0] wr_ptr;
  logic [SGI_FIFO_POW-1:0] rd_ptr;
  logic [CW-1:0]           count;
  logic                    overflow;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    push;
  logic                    pop;
  logic                    push_ok;
  logic                    ovf_set;
  logic                    ovf_clr;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(DEPTH));
  assign pop        = ~fifo_empty & sgi_ack_i;
  assign push       = wr_en & (reg_addr == A_MSI);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok    = push & (~fifo_full | pop);
  assign ovf_set    = push & fifo_full & ~pop;
  assign ovf_clr    = wr_en & (reg_addr == A_SGI_STATUS) & host.wdata[0];

  always_ff @(posedge clk_i) begin
    if (push_ok) fifo_mem[wr_ptr] <= host.wdata[IRQ_NUM_POW-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign sgi_req_o   = ~fifo_empty;
  assign sgi_code_bo = fifo_empty ? '0 : fifo_mem[rd_ptr];

  logic [31:0] sgi_status;
  assign sgi_status = {20'b0, 4'(count), 5'b0, fifo_full, fifo_empty, overflow};

  // ---------------- CPU control ----------------
  logic ctrl_reset;
  logic ctrl_nxt;

  assign ctrl_nxt = (wr_en && reg_addr == A_CTRL) ? host.wdata[0] : ctrl_reset;

  // cpu_reset_o follows the value CTRL takes at this edge, so it moves together with the register.
  always_ff @(posedge clk_i) begin
    cpu_reset_o <= rst_i | ctrl_nxt;
    if (rst_i) ctrl_reset <= (CPU_RESET_DEFAULT != 0);
    else       ctrl_reset <= ctrl_nxt;
  end

  // ---------------- Timer ----------------
`ifdef SFR_EXT_TIMER_EN
  logic [31:0] tmr_cnt;
  logic [31:0] tmr_cmp;
  logic        tmr_en;
  logic        tmr_pend;
  logic        tmr_hit;

  assign tmr_hit = tmr_en & (tmr_cnt == tmr_cmp);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmr_cnt  <= '0;
      tmr_cmp  <= '0;
      tmr_en   <= 1'b0;
      tmr_pend <= 1'b0;
    end else begin
      if (wr_en && reg_addr == A_TIMER_CNT) tmr_cnt <= host.wdata;
      else if (tmr_en)                      tmr_cnt <= tmr_cnt + 32'd1;
      if (wr_en && reg_addr == A_TIMER_CMP)  tmr_cmp <= host.wdata;
      if (wr_en && reg_addr == A_TIMER_CTRL) tmr_en  <= host.wdata[0];
      if (tmr_hit)
        tmr_pend <= 1'b1;
      else if (wr_en && reg_addr == A_TIMER_CTRL && host.wdata[1])
        tmr_pend <= 1'b0;
    end
  end

  assign timer_irq_o = tmr_pend;
`else
  assign timer_irq_o = 1'b0;
`endif

  // ---------------- Read path ----------------
  logic [31:0] rd_val;

  always_comb begin
    rd_val = '0;
    case (reg_addr)
      A_IDCODE:     rd_val = 32'hdeadbeef;
      A_CTRL:       rd_val = {31'b0, ctrl_reset};
      A_CORENUM:    rd_val = 32'(CORENUM);
      A_SGI_STATUS: rd_val = sgi_status;
`ifdef SFR_EXT_TIMER_EN
      A_TIMER_CNT:  rd_val = tmr_cnt;
      A_TIMER_CMP:  rd_val = tmr_cmp;
      A_TIMER_CTRL: rd_val = {30'b0, tmr_pend, tmr_en};
`endif
      default:      rd_val = '0;
    endcase
  end

  logic        resp_r;
  logic [31:0] rdata_r;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_r  <= 1'b0;
      rdata_r <= '0;
    end else begin
      resp_r <= rd_en;
      if (rd_en) rdata_r <= rd_val;
    end
  end

  assign host.resp  = resp_r;
  assign host.rdata = rdata_r;

endmodule

`default_nettype wire

// File: doc/sfr_ext.md
SFR_EXT -- requirements
Module: sfr_ext

Interface
REQ-001 Parameter CORENUM, default 0, core index returned by the CORENUM register.
REQ-002 Parameter CPU_RESET_DEFAULT, default 0, reset value of CTRL bit 0.
REQ-003 Parameter IRQ_NUM_POW, default 4, SGI code width.
REQ-004 Parameter SGI_FIFO_POW, default 2, log2 of SGI FIFO depth (depth = 2^SGI_FIFO_POW, max 8).
REQ-005 Port clk_i  input  1  single clock, all logic on rising edge.
REQ-006 Port rst_i  input  1  reset, synchronous, active-high.
REQ-007 Port host  MemSplit32.Slave  -  register access: req, we, addr, wdata, ack, resp, rdata.
REQ-008 Port cpu_reset_o  output  1  core reset request.
REQ-009 Port sgi_req_o  output  1  SGI valid, high while the SGI FIFO is non-empty.
REQ-010 Port sgi_code_bo  output  IRQ_NUM_POW  SGI code at the FIFO head.
REQ-011 Port sgi_ack_i  input  1  consumer accepts the head SGI.
REQ-012 Port timer_irq_o  output  1  timer compare interrupt level.

Function
REQ-013 The block SHALL decode host.addr[7:0]: 0x00 IDCODE RO 0xdeadbeef; 0x04 CTRL RW bit0 cpu_reset; 0x08 CORENUM RO; 0x0C MSI WO; 0x10 SGI_STATUS; 0x14 TIMER_CNT RW; 0x18 TIMER_CMP RW; 0x1C TIMER_CTRL.
REQ-014 host.ack SHALL equal host.req combinationally; every request is accepted in its cycle.
REQ-015 A read SHALL assert host.resp for exactly one cycle, the cycle after acceptance, with registered rdata; unmapped or WO addresses return 0; writes produce no resp.
REQ-016 cpu_reset_o SHALL be registered as rst_i OR CTRL.cpu_reset (one-cycle latency).
REQ-017 A write to MSI SHALL push wdata[IRQ_NUM_POW-1:0] into the SGI FIFO, visible on sgi_req_o/sgi_code_bo the next cycle.
REQ-018 The FIFO SHALL pop its head on sgi_req_o AND sgi_ack_i; sgi_ack_i while empty is ignored.
REQ-019 Push while full without a same-cycle pop SHALL be dropped and set sticky overflow; push and pop in the same cycle when full SHALL both succeed without overflow.
REQ-020 SGI_STATUS SHALL read [0] overflow, [1] empty, [2] full, [11:8] occupancy count; writing 1 to bit0 clears overflow; a same-cycle new overflow wins over the clear.
REQ-021 Pointers SHALL wrap modulo depth; count SHALL range 0..depth exactly.
REQ-022 TIMER_CTRL SHALL hold [0] enable RW, [1] pending (write 1 clears).
REQ-023 TIMER_CNT SHALL increment by 1 per cycle when enable, wrapping 0xFFFFFFFF to 0; a host write overrides that cycle's increment.
REQ-024 Pending SHALL be set the cycle after TIMER_CNT equals TIMER_CMP while enable; set wins over same-cycle clear; timer_irq_o equals pending.

Reset
REQ-025 On rst_i: FIFO empty, overflow 0, CTRL.cpu_reset = CPU_RESET_DEFAULT, timer count/compare/enable/pending 0, host.resp 0, sgi_req_o 0, sgi_code_bo 0, timer_irq_o 0; cpu_reset_o is 1 the cycle after rst_i is sampled high.
REQ-026 rst_i mid-operation SHALL discard queued SGIs and any read response due that cycle.

Configuration
REQ-027 Macro SFR_EXT_TIMER_EN: defined -> timer registers and timer_irq_o function per REQ-022..024; undefined -> no timer logic, 0x14..0x1C read 0 and ignore writes, timer_irq_o tied 0.

Verification
REQ-028 After reset, read 0x00, 0x08 (CORENUM=3) -> resp next cycle, rdata 0xdeadbeef, 0x00000003.
REQ-029 Write CTRL=1 then CTRL=0 -> cpu_reset_o 1 one cycle after the first write, 0 one cycle after the second.
REQ-030 Depth 4, sgi_ack_i=0, MSI writes 1,2,3,4,5 -> SGI_STATUS=0x405 (full, overflow); ack four cycles -> codes 1,2,3,4, then sgi_req_o 0.
REQ-031 FIFO full, simultaneous MSI write 9 and ack -> no overflow, count stays 4, tail code 9.
REQ-032 Timer: CMP=10, CNT=0, enable -> timer_irq_o high 11 cycles after enable; clear pending -> low; counter wraps from 0xFFFFFFFF to 0.
REQ-033 Assert rst_i with 3 SGIs queued -> sgi_req_o 0, SGI_STATUS=0x002 afterwards.
